// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and holds the fetch/decode pipeline register feeding the core.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_f,
    input  logic                 flush_d,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr_d,
    output logic [31:0]          pc_d,
    output logic [31:0]          pc_plus8_d,
    output logic                 valid_d,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_f_q, pc_f_d;
    logic                   f_valid_q, f_valid_d;
    logic [31:0]            dec_instr_q, dec_instr_d;
    logic [31:0]            dec_pc_q, dec_pc_d;
    logic                   dec_valid_q, dec_valid_d;
    logic [CNT_WIDTH-1:0]   fetch_count_q, fetch_count_d;

    // Redirect target is word-aligned regardless of what the core drives.
    logic [31:0] target_aligned;
    assign target_aligned = branch_target & ~32'h0000_0003;

    // Boot lasts exactly one edge; next-fetch address selection by priority.
    always_comb begin
        state_d   = StRun;
        f_valid_d = 1'b1;
        if (state_q == StBoot) begin
            imem_addr = RESET_PC;
        end else if (branch_taken) begin
            imem_addr = target_aligned;
        end else if (stall_f) begin
            imem_addr = pc_f_q;
        end else begin
            imem_addr = pc_f_q + 32'd4;
        end
        pc_f_d = imem_addr;
    end

    // Decode register: branch/flush insert a bubble, stall holds, else load.
    always_comb begin
        dec_instr_d   = dec_instr_q;
        dec_pc_d      = dec_pc_q;
        dec_valid_d   = dec_valid_q;
        fetch_count_d = fetch_count_q;
        if (branch_taken || flush_d) begin
            dec_instr_d = 32'h0;
            dec_valid_d = 1'b0;
        end else if (!stall_f) begin
            dec_instr_d = imem_rdata;
            dec_pc_d    = pc_f_q;
            dec_valid_d = f_valid_q;
            if (f_valid_q) begin
                fetch_count_d = fetch_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // State, fetch PC and decode register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StBoot;
            pc_f_q        <= RESET_PC;
            f_valid_q     <= 1'b0;
            dec_instr_q   <= 32'h0;
            dec_pc_q      <= 32'h0;
            dec_valid_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_f_q        <= pc_f_d;
            f_valid_q     <= f_valid_d;
            dec_instr_q   <= dec_instr_d;
            dec_pc_q      <= dec_pc_d;
            dec_valid_q   <= dec_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr_d     = dec_instr_q;
    assign pc_d        = dec_pc_q;
    assign valid_d     = dec_valid_q;
    assign fetch_count = fetch_count_q;
    assign pc_plus8_d  = dec_pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/flush/branch
// traffic checked against a transaction-level fetch/decode model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stall_f = 1'b0;
    logic             flush_d = 1'b0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_target = 32'h0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata = 32'h0;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      pc_plus8_d;
    logic             valid_d;
    logic [CNT_W-1:0] fetch_count;

    int errors = 0;
    int checks = 0;

    // Model: address whose data is in flight, whether that data is real,
    // whether the stage is still in its boot cycle, and the decode contents.
    logic        m_boot;
    logic [31:0] m_pcf;
    logic        m_fv;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_vd;
    int          m_cnt;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_f       (stall_f),
        .flush_d       (flush_d),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pc_plus8_d    (pc_plus8_d),
        .valid_d       (valid_d),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hE000_0000;
    endfunction

    // Synchronous instruction memory, one-cycle latency.
    always @(posedge clk) imem_rdata <= mem_f(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("instr_d", instr_d, m_instr);
        chk("pc_d", pc_d, m_pcd);
        chk("pc_plus8_d", pc_plus8_d, m_pcd + 32'd8);
        chk("valid_d", {31'b0, valid_d}, {31'b0, m_vd});
        chk("fetch_count", {28'b0, fetch_count}, m_cnt);
    endtask

    // One clock cycle with the given controls; checks the combinational
    // fetch address before the edge and the decode outputs after it.
    task automatic step(input logic st, input logic fl, input logic br,
                        input logic [31:0] tgt);
        logic [31:0] exp_addr;
        stall_f       = st;
        flush_d       = fl;
        branch_taken  = br;
        branch_target = tgt;
        if (m_boot)   exp_addr = RESET_PC;
        else if (br)  exp_addr = {tgt[31:2], 2'b00};
        else if (st)  exp_addr = m_pcf;
        else          exp_addr = m_pcf + 32'd4;
        #1;
        chk("imem_addr", imem_addr, exp_addr);
        if (br || fl) begin
            m_instr = 32'h0;
            m_vd    = 1'b0;
        end else if (!st) begin
            m_instr = mem_f(m_pcf);
            m_pcd   = m_pcf;
            m_vd    = m_fv;
            if (m_fv) m_cnt = (m_cnt + 1) % 16;
        end
        m_pcf  = exp_addr;
        m_fv   = 1'b1;
        m_boot = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Assert reset between edges, check it takes effect at once, then hold
    // it across two edges and release it away from an edge.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        #1;
        m_boot  = 1'b1;
        m_pcf   = RESET_PC;
        m_fv    = 1'b0;
        m_instr = 32'h0;
        m_pcd   = 32'h0;
        m_vd    = 1'b0;
        m_cnt   = 0;
        check_outputs();
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_pc_plus8", pc_plus8_d, 32'd8);
        stall_f      = 1'b0;
        flush_d      = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic st, fl, br;
        logic [31:0] tgt;

        // Reset and boot.
        apply_reset();
        step(0, 0, 0, 0);
        chk("boot_valid0", {31'b0, valid_d}, 32'd0);
        step(0, 0, 0, 0);
        chk("first_valid", {31'b0, valid_d}, 32'd1);
        chk("first_pc", pc_d, 32'h0);
        chk("first_instr", instr_d, 32'hE000_0000);
        chk("first_pc8", pc_plus8_d, 32'd8);
        step(0, 0, 0, 0);
        chk("second_instr", instr_d, 32'hE000_0004);
        step(0, 0, 0, 0);
        chk("third_pc", pc_d, 32'h8);
        chk("third_pc8", pc_plus8_d, 32'd16);

        // Three-cycle stall with pc_d = 8.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("stall_pc_hold", pc_d, 32'h8);
            chk("stall_cnt_hold", {28'b0, fetch_count}, 32'd3);
            chk("stall_addr_hold", imem_addr, 32'hC);
        end
        step(0, 0, 0, 0);
        chk("post_stall_pc", pc_d, 32'hC);
        step(0, 0, 0, 0);
        chk("post_stall_pc2", pc_d, 32'h10);

        // Taken branch to an unaligned target.
        step(0, 0, 1, 32'h103);
        chk("br_bubble", {31'b0, valid_d}, 32'd0);
        step(0, 0, 0, 0);
        chk("br_target_pc", pc_d, 32'h100);
        step(0, 0, 0, 0);
        chk("br_next_pc", pc_d, 32'h104);

        // Branch beats stall and flush together.
        step(1, 1, 1, 32'h40);
        chk("all3_bubble", {31'b0, valid_d}, 32'd0);
        chk("all3_cnt", {28'b0, fetch_count}, 32'd7);
        step(0, 0, 0, 0);
        chk("all3_pc", pc_d, 32'h40);

        // Flush during stall still clears decode.
        step(1, 1, 0, 0);
        chk("flush_stall", {31'b0, valid_d}, 32'd0);

        // PC wraps past the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFF8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_top", pc_d, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_zero", pc_d, 32'h0);

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom % 4) == 0;
            fl  = ($urandom % 10) == 0;
            br  = ($urandom % 10) == 0;
            tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 + ($urandom % 8) : $urandom;
            step(st, fl, br, tgt);
        end

        // Mid-stream reset, then counter wrap over 17 unstalled fetches.
        apply_reset();
        for (int i = 1; i <= 18; i++) begin
            step(0, 0, 0, 0);
            if (i == 16) chk("cnt_15", {28'b0, fetch_count}, 32'd15);
            if (i == 17) chk("cnt_wrap0", {28'b0, fetch_count}, 32'd0);
            if (i == 18) chk("cnt_wrap1", {28'b0, fetch_count}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the ARM pipelined core's decode input. It owns the program counter and drives a synchronous (1-cycle-latency) instruction memory. It also holds the fetch/decode pipeline register that supplies `Instruction`/`PC` to the core. It handles stall, flush and taken-branch redirect from the core's hazard logic, and counts instructions delivered to decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; low 2 bits must be 0.
- `CNT_WIDTH`, default 32: width of `fetch_count`.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall_f`  in  1  hold the PC and the decode register.
- `flush_d`  in  1  clear the decode register (insert bubble).
- `branch_taken`  in  1  redirect fetch to `branch_target` this cycle.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored (forced 0).
- `imem_addr`  out  32  address presented to instruction memory (combinational).
- `imem_rdata`  in  32  memory word for the address presented on the previous edge.
- `instr_d`  out  32  instruction to decode.
- `pc_d`  out  32  address of `instr_d`.
- `pc_plus8_d`  out  32  `pc_d + 8`, the architectural R15 read value (combinational).
- `valid_d`  out  1  `instr_d` is a real instruction (0 = bubble).
- `fetch_count`  out  CNT_WIDTH  count of valid instructions loaded into decode.

## Operation
- State machine with two states:
  - BOOT is entered on reset.
  - BOOT → RUN on the first edge after reset deasserts, unconditionally.
  - RUN persists until the next reset.
- Internal registers:
  - `pc_f` (address whose data is on `imem_rdata`); reset value RESET_PC.
  - `f_valid` (`imem_rdata` is meaningful); reset value 0.
- Next-fetch address, which drives `imem_addr` combinationally, by priority:
  - BOOT → RESET_PC.
  - `branch_taken` → {`branch_target[31:2]`, 2'b00}.
  - `stall_f` → `pc_f`.
  - otherwise → `pc_f + 4`, modulo 2^32; 0xFFFF_FFFC wraps to 0.
- Every edge: `pc_f <= imem_addr`; `f_valid <= 1` (after BOOT).
- Decode register update, by priority:
  - `branch_taken` or `flush_d` → `instr_d = 0`, `valid_d = 0`, `pc_d` unchanged.
  - `stall_f` → hold all fields.
  - otherwise → `instr_d <= imem_rdata`, `pc_d <= pc_f`, `valid_d <= f_valid`.
- Branch overrides stall for both the PC and the decode register. A flush during a stall still clears decode.
- `fetch_count` increments by 1 on each edge where decode loads with `f_valid = 1`, i.e. the "otherwise" case. It wraps from 2^CNT_WIDTH − 1 to 0.
- Reset values of outputs:
  - `instr_d` = 0, `pc_d` = 0, `valid_d` = 0, `fetch_count` = 0.
  - `pc_plus8_d` = 8.
  - `imem_addr` = RESET_PC.
- Asynchronous reset mid-operation forces all of the above immediately, without waiting for a clock edge, and returns the state machine to BOOT.

## Timing
- Memory contract: `imem_rdata` after edge N equals mem[`imem_addr` sampled at edge N].
- After reset release:
  - Edge 1: BOOT → RUN, `pc_f` = RESET_PC.
  - Edge 2: first `valid_d = 1`, with `pc_d = RESET_PC`.
- Steady state: one instruction per cycle, with `pc_d` stepping by 4.
- Stall: `imem_addr` re-presents `pc_f`, so no instruction is skipped or duplicated on release.
- Taken branch asserted in cycle T:
  - Edge T+1: `valid_d = 0` (one bubble).
  - Edge T+2: `pc_d = target`, `valid_d = 1`.
- No combinational path from `imem_rdata` to any output.

## Test plan
- Reset/boot, RESET_PC = 0, mem[a] = a ^ 32'hE000_0000 → `valid_d` is first 1 after the 2nd edge, with `pc_d` = 0, 4, 8 and `instr_d` = 0xE000_0000, 0xE000_0004, 0xE000_0008 on consecutive cycles; `pc_plus8_d` = 8, 12, 16.
- `stall_f` high for 3 cycles while `pc_d` = 0x8 → `pc_d`, `instr_d` and `fetch_count` are held; `imem_addr` is held at 0xC; after release, `pc_d` = 0xC, then 0x10.
- `branch_taken` with target 0x103 while in RUN → `imem_addr` = 0x100 the same cycle; one cycle with `valid_d = 0`; then `pc_d` = 0x100, 0x104.
- `stall_f`, `branch_taken` (target 0x40) and `flush_d` all high together → the branch wins: a bubble, then `pc_d` = 0x40; `fetch_count` does not increment in the bubble cycle.
- Assert `reset` mid-stream between clock edges → `valid_d`, `instr_d`, `pc_d` and `fetch_count` go to 0 and `imem_addr` goes to RESET_PC without waiting for an edge; the boot sequence then repeats.
- With `CNT_WIDTH` = 4, run 17 unstalled fetches after boot → `fetch_count` reads 15 after the 15th valid load, 0 after the 16th, and 1 after the 17th.
